vga_bounce_gen: RTL and testbench
=================================

// Module: vga_bounce_gen
// PURPOSE
//  Pixel generator directly downstream of vga_sync. Draws an 800x600 frame:
//  a 1-px white border, a dark background and a solid square that moves
//  once per frame and bounces off the visible edges. Square colour steps
//  through an 8-entry palette on each bounce. Sync is re-timed so that RGB,
//  h_sync and v_sync leave the block aligned, with 1-cycle latency.
// PARAMETERS
//  H_VISIBLE  800  visible pixels per line (matches vga_sync)
//  V_VISIBLE  600  visible lines per frame (matches vga_sync)
//  BOX_SIZE   32   square edge length, px
//  SPEED      2    px moved per frame on each axis (1..BOX_SIZE)
//  INIT_X     100  square left edge after reset
//  INIT_Y     100  square top edge after reset
// PORTS
//  clk         in   1   pixel clock, shared with vga_sync
//  rst         in   1   async active-low reset
//  h_sync_in   in   1   from vga_sync.h_sync
//  v_sync_in   in   1   from vga_sync.v_sync (high during sync pulse)
//  display_en  in   1   from vga_sync; x_pos/y_pos valid only when high
//  x_pos       in   11  current column (may be Z when display_en=0)
//  y_pos       in   11  current line (may be Z when display_en=0)
//  pause       in   1   1 = freeze square motion (sync-level, clk domain)
//  vga_r       out  4   red
//  vga_g       out  4   green
//  vga_b       out  4   blue
//  h_sync      out  1   h_sync_in delayed 1 clk
//  v_sync      out  1   v_sync_in delayed 1 clk
//  frame_tick  out  1   1-clk pulse on v_sync_in rising edge
// BEHAVIOUR
//  Reset (rst=0, async): RGB=0, h_sync=0, v_sync=0, frame_tick=0,
//   box_x=INIT_X, box_y=INIT_Y, dir_x=+, dir_y=+, colour_idx=0, v_prev=0.
//   Reset mid-frame discards all motion state. Outputs stay 0 until the
//   first clk edge after release.
//  Frame tick: v_prev <= v_sync_in every clk; frame_tick <= v_sync_in & ~v_prev.
//   Motion updates on the clk where frame_tick=1, i.e. during vertical sync,
//   so the square never tears within a visible frame.
//  Motion per axis (X shown; Y same, with V_VISIBLE), when tick & ~pause:
//   dir +: if box_x+BOX_SIZE+SPEED >= H_VISIBLE -> box_x=H_VISIBLE-BOX_SIZE,
//          dir=-, bounce; else box_x+=SPEED.
//   dir -: if box_x <= SPEED -> box_x=0, dir=+, bounce; else box_x-=SPEED.
//   All sums are 12 bits wide so they cannot overflow.
//   If either axis bounces, colour_idx increments by 1 (mod 8). A corner
//   hit (both axes on the same tick) increments it by exactly 1.
//   pause=1: position, dir and colour are held. frame_tick still pulses.
//  Pixel (registered, 1-clk latency; inputs sampled on the same edge):
//   display_en=0                               -> 000 (X/Z inputs ignored)
//   x==0|x==H_VISIBLE-1|y==0|y==V_VISIBLE-1    -> FFF border (top priority)
//   box_x<=x<box_x+BOX_SIZE & box_y<=y<box_y+BOX_SIZE -> palette[colour_idx]
//   otherwise                                  -> 112 background
//   Palette RGB444: 0:F00 1:0F0 2:00F 3:FF0 4:0FF 5:F0F 6:FFF 7:F80.
//  h_sync/v_sync: plain 1-clk delay of the inputs. Polarity is unchanged.
// TESTING
//  1 reset: rst=0 mid-line -> all outputs 0 at once. After release, box at
//    (100,100), colour_idx=0.
//  2 motion: 1 v_sync_in rise -> frame_tick high for exactly 1 clk, box
//    (102,102). Pixel (110,110) shows F00; (99,110) shows 112.
//  3 right bounce: box_x=766, dir + -> tick -> box_x=768, dir -,
//    colour_idx=1. Next tick -> 766.
//  4 corner: box (2,2), both dir - -> tick -> (0,0), both dir +,
//    colour_idx incremented by 1 only. Pixel (0,0) shows FFF border.
//  5 pause: pause=1 over 3 ticks -> box and colour unchanged, 3 frame_tick pulses.
//  6 alignment: drive a full 1040x666 vga_sync frame with X on x/y_pos
//    when display_en=0 -> no X on RGB. h_sync/v_sync equal inputs delayed
//    1 clk; RGB=0 outside the visible area.

Source files
------------

// File: rtl/vga_bounce_gen.sv
// Pixel generator behind vga_sync: white border, dark background and a bouncing
// square whose colour steps through a palette on every bounce. 1-clk aligned output.
module vga_bounce_gen #(
  parameter int H_VISIBLE = 800,
  parameter int V_VISIBLE = 600,
  parameter int BOX_SIZE  = 32,
  parameter int SPEED     = 2,
  parameter int INIT_X    = 100,
  parameter int INIT_Y    = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic        display_en,
  input  logic [10:0] x_pos,
  input  logic [10:0] y_pos,
  input  logic        pause,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        h_sync,
  output logic        v_sync,
  output logic        frame_tick
);

  // Per-axis direction state
  //   state   | meaning
  //   DIR_POS | square moving right/down, bounces at the far visible edge
  //   DIR_NEG | square moving left/up, bounces at coordinate 0
  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  typedef struct packed {
    logic [10:0] pos;
    dir_t        dir;
    logic        bounce;
  } axis_t;

  localparam logic [11:0] H_LIM = 12'(H_VISIBLE);
  localparam logic [11:0] V_LIM = 12'(V_VISIBLE);
  localparam logic [11:0] BOX_W = 12'(BOX_SIZE);
  localparam logic [11:0] SPD_W = 12'(SPEED);

  function automatic axis_t axis_step(input logic [10:0] pos, input dir_t dir,
                                      input logic [11:0] lim);
    axis_t r;
    r.pos    = pos;
    r.dir    = dir;
    r.bounce = 1'b0;
    if (dir == DIR_POS) begin
      if ({1'b0, pos} + BOX_W + SPD_W >= lim) begin
        r.pos    = 11'(lim - BOX_W);
        r.dir    = DIR_NEG;
        r.bounce = 1'b1;
      end else begin
        r.pos = pos + SPD_W[10:0];
      end
    end else begin
      if ({1'b0, pos} <= SPD_W) begin
        r.pos    = '0;
        r.dir    = DIR_POS;
        r.bounce = 1'b1;
      end else begin
        r.pos = pos - SPD_W[10:0];
      end
    end
    return r;
  endfunction

  function automatic logic [11:0] palette(input logic [2:0] idx);
    logic [11:0] c;
    case (idx)
      3'd0:    c = 12'hF00;
      3'd1:    c = 12'h0F0;
      3'd2:    c = 12'h00F;
      3'd3:    c = 12'hFF0;
      3'd4:    c = 12'h0FF;
      3'd5:    c = 12'hF0F;
      3'd6:    c = 12'hFFF;
      default: c = 12'hF80;
    endcase
    return c;
  endfunction

  logic [10:0] box_x, box_y, box_x_nxt, box_y_nxt;
  dir_t        dir_x, dir_y, dir_x_nxt, dir_y_nxt;
  logic [2:0]  colour_idx, colour_nxt;
  logic        v_prev;
  axis_t       ax_x, ax_y;

  // Motion state register; updates only on the frame_tick clock (inside v-sync)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      box_x      <= 11'(INIT_X);
      box_y      <= 11'(INIT_Y);
      dir_x      <= DIR_POS;
      dir_y      <= DIR_POS;
      colour_idx <= 3'd0;
    end else begin
      box_x      <= box_x_nxt;
      box_y      <= box_y_nxt;
      dir_x      <= dir_x_nxt;
      dir_y      <= dir_y_nxt;
      colour_idx <= colour_nxt;
    end
  end

  always_comb begin
    box_x_nxt  = box_x;
    box_y_nxt  = box_y;
    dir_x_nxt  = dir_x;
    dir_y_nxt  = dir_y;
    colour_nxt = colour_idx;
    ax_x       = axis_step(box_x, dir_x, H_LIM);
    ax_y       = axis_step(box_y, dir_y, V_LIM);
    if (frame_tick && !pause) begin
      box_x_nxt = ax_x.pos;
      dir_x_nxt = ax_x.dir;
      box_y_nxt = ax_y.pos;
      dir_y_nxt = ax_y.dir;
      // a corner hit bounces both axes but advances the palette only once
      if (ax_x.bounce || ax_y.bounce) begin
        colour_nxt = colour_idx + 3'd1;
      end
    end
  end

  logic [11:0] xe, ye, pix_nxt;
  logic        border, in_box;

  always_comb begin
    xe      = {1'b0, x_pos};
    ye      = {1'b0, y_pos};
    border  = (x_pos == 11'd0) || (x_pos == 11'(H_VISIBLE - 1)) ||
              (y_pos == 11'd0) || (y_pos == 11'(V_VISIBLE - 1));
    in_box  = (xe >= {1'b0, box_x}) && (xe < {1'b0, box_x} + BOX_W) &&
              (ye >= {1'b0, box_y}) && (ye < {1'b0, box_y} + BOX_W);
    pix_nxt = 12'h000;
    // x/y_pos are only trusted while display_en is high
    if (display_en) begin
      if (border) begin
        pix_nxt = 12'hFFF;
      end else if (in_box) begin
        pix_nxt = palette(colour_idx);
      end else begin
        pix_nxt = 12'h112;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_r      <= 4'h0;
      vga_g      <= 4'h0;
      vga_b      <= 4'h0;
      h_sync     <= 1'b0;
      v_sync     <= 1'b0;
      v_prev     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= pix_nxt;
      h_sync     <= h_sync_in;
      v_sync     <= v_sync_in;
      v_prev     <= v_sync_in;
      frame_tick <= v_sync_in & ~v_prev;
    end
  end

endmodule

// File: tb/tb_vga_bounce_gen.sv
// Bench for vga_bounce_gen: directed + random steps against a behavioural model.
// A second instance with a square 600x600 field gives a reachable corner bounce.
module tb_vga_bounce_gen;

  logic clk = 1'b0, rst = 1'b0;
  logic h_sync_in = 1'b0, v_sync_in = 1'b0, display_en = 1'b0, pause = 1'b0;
  logic [10:0] x_pos = '0, y_pos = '0;
  logic [3:0] r0, g0, b0, r1, g1, b1;
  logic hs0, vs0, ft0, hs1, vs1, ft1;

  vga_bounce_gen dut0 (
    .clk(clk), .rst(rst), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .display_en(display_en), .x_pos(x_pos), .y_pos(y_pos), .pause(pause),
    .vga_r(r0), .vga_g(g0), .vga_b(b0), .h_sync(hs0), .v_sync(vs0), .frame_tick(ft0)
  );

  vga_bounce_gen #(.H_VISIBLE(600)) dut1 (
    .clk(clk), .rst(rst), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .display_en(display_en), .x_pos(x_pos), .y_pos(y_pos), .pause(pause),
    .vga_r(r1), .vga_g(g1), .vga_b(b1), .h_sync(hs1), .v_sync(vs1), .frame_tick(ft1)
  );

  always #5 clk = ~clk;

  wire [11:0] rgb0 = {r0, g0, b0};
  wire [11:0] rgb1 = {r1, g1, b1};

  int checks = 0, errors = 0, pulses = 0;
  int bx[2], by[2], dx[2], dy[2], ci[2];
  int hv[2] = '{800, 600};
  logic m_tick, m_vprev;
  logic [11:0] pal[8] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
                          12'h0FF, 12'hF0F, 12'hFFF, 12'hF80};

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      bx[i] = 100; by[i] = 100; dx[i] = 1; dy[i] = 1; ci[i] = 0;
    end
    m_tick = 1'b0; m_vprev = 1'b0;
  endtask

  function automatic logic [11:0] exp_pix(input int i, input logic de, input int x, input int y);
    if (!de) return 12'h000;
    if (x == 0 || x == hv[i] - 1 || y == 0 || y == 599) return 12'hFFF;
    if (x >= bx[i] && x < bx[i] + 32 && y >= by[i] && y < by[i] + 32) return pal[ci[i]];
    return 12'h112;
  endfunction

  // One axis of the square: reflect at 0 and at limit-32, report if it bounced
  task automatic move_axis(inout int p, inout int d, input int lim, output bit b);
    b = 0;
    if (d > 0) begin
      if (p + 34 >= lim) begin p = lim - 32; d = -1; b = 1; end
      else p += 2;
    end else begin
      if (p <= 2) begin p = 0; d = 1; b = 1; end
      else p -= 2;
    end
  endtask

  task automatic model_move(input int i);
    bit bxx, byy;
    move_axis(bx[i], dx[i], hv[i], bxx);
    move_axis(by[i], dy[i], 600, byy);
    if (bxx || byy) ci[i] = (ci[i] + 1) % 8;
  endtask

  task automatic step(input logic hs, input logic vs, input logic de, input int x, input int y);
    logic [11:0] e0, e1;
    logic et;
    h_sync_in  = hs;
    v_sync_in  = vs;
    display_en = de;
    x_pos      = de ? 11'(x) : 11'bx;
    y_pos      = de ? 11'(y) : 11'bx;
    e0 = exp_pix(0, de, x, y);
    e1 = exp_pix(1, de, x, y);
    et = vs & ~m_vprev;
    @(posedge clk);
    #1;
    if (m_tick && !pause) begin
      model_move(0);
      model_move(1);
    end
    m_tick  = et;
    m_vprev = vs;
    if (ft0) pulses++;
    check("rgb0", rgb0, e0);
    check("rgb1", rgb1, e1);
    check("h_sync", {11'b0, hs0}, {11'b0, hs});
    check("v_sync", {11'b0, vs0}, {11'b0, vs});
    check("frame_tick", {10'b0, ft1, ft0}, {10'b0, et, et});
  endtask

  task automatic do_tick();
    step(1'b0, 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic probe(input int x, input int y);
    step(1'b0, 1'b0, 1'b1, x, y);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rgb0"}, rgb0, 12'h000);
    check({tag, "_rgb1"}, rgb1, 12'h000);
    check({tag, "_sync"}, {6'b0, hs0, vs0, ft0, hs1, vs1, ft1}, 12'h000);
  endtask

  int lines[16] = '{0, 1, 2, 50, 101, 120, 300, 598, 599, 600, 636, 637, 638, 642, 643, 665};
  int guard, yy, c0, p0;

  initial begin
    model_reset();
    #12 check_zero("por");
    @(posedge clk); #3 rst = 1'b1;
    check_zero("por_release");

    // 1: async reset mid-line
    step(1'b1, 1'b0, 1'b1, 0, 5);
    step(1'b1, 1'b0, 1'b1, 5, 5);
    check("pre_reset_hs", {11'b0, hs0}, 12'h001);
    #2 rst = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    @(posedge clk); #2 rst = 1'b1;
    #1 check_zero("rst_release");
    probe(100, 100); check("init_box", rgb0, 12'hF00);
    probe(99, 100);  check("init_left", rgb0, 12'h112);
    probe(131, 131); check("init_br", rgb0, 12'hF00);
    probe(132, 131); check("init_right", rgb0, 12'h112);

    // 2: one frame of motion
    step(1'b0, 1'b1, 1'b0, 0, 0); check("tick_hi", {11'b0, ft0}, 12'h001);
    step(1'b0, 1'b0, 1'b0, 0, 0); check("tick_lo", {11'b0, ft0}, 12'h000);
    probe(110, 110); check("moved_in", rgb0, 12'hF00);
    probe(99, 110);  check("moved_out", rgb0, 12'h112);
    probe(101, 102); check("moved_edge", rgb0, 12'h112);
    probe(102, 102); check("moved_tl", rgb0, 12'hF00);

    // 3: right bounce
    guard = 0;
    while (!(bx[0] == 766 && dx[0] == 1) && guard < 1000) begin do_tick(); guard++; end
    check("reach_766", 12'(guard < 1000), 12'h001);
    c0 = ci[0];
    do_tick();
    yy = by[0] + 1;
    probe(768, yy); check("rb_768", rgb0, pal[(c0 + 1) % 8]);
    probe(767, yy); check("rb_767", rgb0, 12'h112);
    do_tick();
    yy = by[0] + 1;
    probe(766, yy); check("rb_back", rgb0, pal[ci[0]]);
    probe(765, yy); check("rb_back_out", rgb0, 12'h112);

    // 4: corner on the square-field instance
    guard = 0;
    while (!(bx[1] == 2 && by[1] == 2 && dx[1] < 0 && dy[1] < 0) && guard < 2000) begin
      do_tick(); guard++;
    end
    check("reach_corner", 12'(guard < 2000), 12'h001);
    c0 = ci[1];
    do_tick();
    probe(0, 0);   check("corner_border", rgb1, 12'hFFF);
    probe(1, 1);   check("corner_box", rgb1, pal[(c0 + 1) % 8]);
    probe(31, 31); check("corner_far", rgb1, pal[(c0 + 1) % 8]);
    probe(32, 1);  check("corner_out", rgb1, 12'h112);
    do_tick();
    probe(1, 1);   check("corner_away", rgb1, 12'h112);
    probe(2, 2);   check("corner_dirpos", rgb1, pal[(c0 + 1) % 8]);

    // 5: pause holds motion but ticks still pulse
    pause = 1'b1;
    p0 = pulses;
    repeat (3) do_tick();
    pause = 1'b0;
    check("pause_pulses", 12'(pulses - p0), 12'd3);
    probe(bx[0], by[0]);
    probe(bx[0] + 31, by[0] + 31);
    probe(bx[1], by[1]);

    // random motion, pausing and probes
    repeat (150) begin
      pause = ($urandom_range(0, 3) == 0);
      do_tick();
      pause = 1'b0;
      repeat (3) step(1'b0, 1'b0, 1'($urandom_range(0, 7) != 0),
                      int'($urandom_range(0, 799)), int'($urandom_range(0, 599)));
      probe(bx[0] + int'($urandom_range(0, 33)) - 1, by[0] + int'($urandom_range(0, 33)) - 1);
    end

    // 6: full-width 1040-clock lines from a 666-line frame, X on coordinates in blanking
    foreach (lines[k]) begin
      for (int h = 0; h < 1040; h++) begin
        step(1'(h >= 856 && h < 976), 1'(lines[k] >= 637 && lines[k] < 643),
             1'(lines[k] < 600 && h < 800), h, lines[k]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
